ex_mem_pipe_reg: RTL

//  Parametrised EX/MEM pipeline register with valid/ready handshake, 2-entry skid buffer and flush.

---
 rtl/ex_mem_pkg.sv | 24 ++
 rtl/pipe_skid_buf.sv | 81 ++++++++
 rtl/ex_mem_pipe_reg.sv | 90 +++++++++
 3 files changed

// File: rtl/ex_mem_pkg.sv
// rtl/ex_mem_pkg.sv - EX/MEM stage control struct, skid state encoding and memory access sizes
package ex_mem_pkg;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic [2:0] mem_size;
    } exmem_ctrl_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } exmem_state_e;

    localparam logic [2:0] MEM_SIZE_B  = 3'b000;
    localparam logic [2:0] MEM_SIZE_H  = 3'b001;
    localparam logic [2:0] MEM_SIZE_W  = 3'b010;
    localparam logic [2:0] MEM_SIZE_BU = 3'b100;
    localparam logic [2:0] MEM_SIZE_HU = 3'b101;

endpackage

// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - generic 2-entry skid buffer with registered in_ready and sync flush
module pipe_skid_buf
    import ex_mem_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    exmem_state_e state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         in_ready_q, in_ready_d;
    logic         in_fire;
    logic         out_fire;

    assign in_fire   = in_valid & in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_fire  = out_valid & out_ready;
    assign in_ready  = in_ready_q;
    assign out_data  = main_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = ONE;
                    main_d  = in_data;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (in_fire) begin
                    state_d = TWO;
                    skid_d  = in_data;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (out_fire) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush wins over everything; payload may go stale, validity does not.
        if (flush) begin
            state_d = EMPTY;
        end
        in_ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// rtl/ex_mem_pipe_reg.sv - EX/MEM pipeline register with skid buffer, sanitise and flush
// Optional stall counter enabled by defining EXMEM_STALL_CNT_EN.
module ex_mem_pipe_reg
    import ex_mem_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   alu_out_in,
    input  logic [XLEN-1:0]   store_data_in,
    input  logic [REG_AW-1:0] rd_ex_in,
    input  exmem_ctrl_t       ctrl_in,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   alu_out_exmem,
    output logic [XLEN-1:0]   store_data_exmem,
    output logic [REG_AW-1:0] rd_exmem,
    output exmem_ctrl_t       ctrl_exmem,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int CW = $bits(exmem_ctrl_t);
    localparam int PW = CW + REG_AW + 2 * XLEN;

    exmem_ctrl_t   ctrl_san;
    exmem_ctrl_t   ctrl_main;
    logic [PW-1:0] in_payload;
    logic [PW-1:0] out_payload;

    // x0 is never a writeback target, and a load+store encoding is treated as a load.
    always_comb begin
        ctrl_san = ctrl_in;
        if (ctrl_in.mem_read && ctrl_in.mem_write) begin
            ctrl_san.mem_write = 1'b0;
        end
        if (rd_ex_in == '0) begin
            ctrl_san.reg_write  = 1'b0;
            ctrl_san.mem_to_reg = 1'b0;
        end
    end

    assign in_payload = {ctrl_san, rd_ex_in, store_data_in, alu_out_in};

    pipe_skid_buf #(
        .W (PW)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_payload),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_payload)
    );

    assign {ctrl_main, rd_exmem, store_data_exmem, alu_out_exmem} = out_payload;
    assign ctrl_exmem = out_valid ? ctrl_main : '0;

`ifdef EXMEM_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
